int_to_float_seq: RTL
=====================

# int_to_float_seq

Parametrised, handshaked fixed-point-to-IEEE-754 converter. It accepts an unsigned magnitude with FRAC_BITS fractional bits plus a sign, locates the leading one with a bit-serial MSB-down scan, and packs sign, biased exponent and mantissa into a floating-point word. It sits between the integer datapath and the float formatting stage. It generalises the combinational leading-one/exponent logic to arbitrary widths, with rounding, overflow/underflow flags and valid/ready flow control.

## Interface
- IN_WIDTH, 128: magnitude width, ≥ 2
- FRAC_BITS, 12: fractional bits in in_data; unbiased exponent = p − FRAC_BITS, where p = leading-one index
- EXP_W, 8: exponent field width
- MAN_W, 23: mantissa field width
- EXP_BIAS, 127: exponent bias
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  IN_WIDTH  unsigned magnitude
- in_sign  in  1  sign bit, passed through
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_float  out  1+EXP_W+MAN_W  {sign, exponent, mantissa}
- out_lead  out  $clog2(IN_WIDTH)  leading-one index p; 0 for zero input
- out_zero  out  1  input magnitude was zero
- out_oflow  out  1  result saturated to infinity
- out_uflow  out  1  result flushed to signed zero

## Operation
- FSM: IDLE → SCAN → PACK → DONE → IDLE.
- IDLE: in_ready=1. On in_valid, capture in_data, in_sign and idx=IN_WIDTH−1.
  - Zero magnitude: go straight to DONE with out_float={in_sign,0…}, out_zero=1, out_lead=0.
  - Otherwise go to SCAN.
- SCAN: each cycle test data[idx].
  - Set: p=idx, go to PACK.
  - Clear: idx−1.
  - idx never underflows because nonzero input is guaranteed.
- PACK: one cycle.
  - E = p − FRAC_BITS + EXP_BIAS, computed signed with width $clog2(IN_WIDTH)+EXP_W+2.
  - Mantissa = bits p−1..p−MAN_W, MSB-aligned; zero-padded below bit 0 when p < MAN_W.
  - Rounding per Configuration. Mantissa carry-out clears the mantissa and adds 1 to E.
  - E ≤ 0: flush to {sign,0,0}, out_uflow=1.
  - E ≥ 2^EXP_W−1: {sign,all-ones,0}, out_oflow=1.
  - No subnormals are generated.
- DONE: out_valid=1. All outputs stay stable until out_ready. On out_valid&out_ready, go to IDLE.
- Flags are mutually exclusive and are valid only while out_valid=1.

## Timing
- Reset (rst_n low at clk edge): state=IDLE, in_ready=1 the following cycle, out_valid=0, out_float=0, out_lead=0, all flags 0. Reset mid-SCAN/PACK/DONE discards the pending word.
- Accept at edge 0. Nonzero input: out_valid rises at edge 3+(IN_WIDTH−1−p). Zero input: out_valid rises at edge 1.
- No bypass. After an output handshake, in_ready is high the next cycle, so the minimum issue interval is latency+1 cycles.
- in_ready is low throughout SCAN/PACK/DONE. in_data is ignored there.
- Backpressure is unbounded. out_* hold stable while out_valid & ~out_ready.

## Configuration
- Macro ROUND_NEAREST_EN.
- Defined: round-to-nearest-even.
  - guard = bit p−MAN_W−1; sticky = OR of the bits below guard.
  - Increment when guard & (sticky | mantissa LSB).
  - guard and sticky are 0 when p ≤ MAN_W.
- Undefined: truncation. The rounding adder is absent; E carry and overflow come only from the exponent.

## Test plan
Defaults unless stated.
- **Unity:** in_data=1<<12, sign 0 → out_float=0x3F800000, out_lead=12; out_valid 118 cycles after accept.
- **Zero:** in_data=0, sign 1 → out_float=0x80000000, out_zero=1; out_valid 1 cycle after accept.
- **Rounding:**
  - (1<<36)|(1<<12)|(1<<11) → 0x4B800001 with ROUND_NEAREST_EN, 0x4B800000 without.
  - (1<<36)|(1<<12) (tie, even) → 0x4B800000 in both builds.
- **Carry:** in_data all ones → 0x79800000 with ROUND_NEAREST_EN, 0x797FFFFF without; out_lead=127.
- **Underflow:** FRAC_BITS=130, in_data=1, sign 1 → 0x80000000, out_uflow=1.
- **Reset/backpressure:**
  - rst_n low for one cycle mid-SCAN → out_valid never rises; in_ready=1 the following cycle.
  - out_ready held low 20 cycles in DONE → out_float stable, no new accept.

Source files
------------

// File: rtl/int_to_float_seq.sv
// int_to_float_seq: sequential fixed-point magnitude + sign to IEEE-754 style
// float converter with valid/ready handshake on both sides.
// The leading one is found by an MSB-down scan that shifts the captured
// magnitude left one bit per cycle until its top bit is set. The word is then
// normalised, and the mantissa and guard/sticky bits are read from fixed
// positions.
// Optional build macro: ROUND_NEAREST_EN selects round-to-nearest-even.
// Without it, the mantissa is truncated.
module int_to_float_seq #(
    parameter int IN_WIDTH  = 128,
    parameter int FRAC_BITS = 12,
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int EXP_BIAS  = 127
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic                          in_sign,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_W+MAN_W:0]          out_float,
    output logic [$clog2(IN_WIDTH)-1:0]   out_lead,
    output logic                          out_zero,
    output logic                          out_oflow,
    output logic                          out_uflow
);
    localparam int LW = $clog2(IN_WIDTH);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int EW = LW + EXP_W + 2;
    // Normalised word padded with MAN_W+1 zeros, so that the mantissa and
    // guard fields always exist even when p < MAN_W.
    localparam int NW = IN_WIDTH + MAN_W + 1;

    localparam logic signed [EW-1:0] E_OFF = EW'(EXP_BIAS - FRAC_BITS);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_PACK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_reg;
    logic [IN_WIDTH-1:0] data_reg;
    logic [LW-1:0]       idx_reg;
    logic                sign_reg;
    logic                out_valid_reg;
    logic [FW-1:0]       out_float_reg;
    logic [LW-1:0]       out_lead_reg;
    logic                out_zero_reg;
    logic                out_oflow_reg;
    logic                out_uflow_reg;

    logic [NW-1:0]          norm;
    logic [MAN_W-1:0]       man_raw;
    logic [MAN_W-1:0]       man_fin;
    logic signed [EW-1:0]   e_base;
    logic signed [EW-1:0]   e_fin;
    logic [FW-1:0]          pack_float;
    logic                   pack_oflow;
    logic                   pack_uflow;
    logic                   unused_norm;

    // After the scan, data_reg holds the magnitude with its leading one at the MSB.
    assign norm    = {data_reg, {(MAN_W + 1){1'b0}}};
    assign man_raw = norm[NW-2 -: MAN_W];
    assign e_base  = EW'(idx_reg) + E_OFF;

`ifdef ROUND_NEAREST_EN
    logic             guard_bit;
    logic             sticky_bit;
    logic             round_up;
    logic [MAN_W:0]   man_sum;

    assign guard_bit   = norm[NW-2-MAN_W];
    assign sticky_bit  = |norm[NW-3-MAN_W:0];
    assign round_up    = guard_bit & (sticky_bit | man_raw[0]);
    assign man_sum     = {1'b0, man_raw} + (MAN_W + 1)'(round_up);
    // A carry out of the mantissa leaves the low bits at zero and bumps the exponent.
    assign man_fin     = man_sum[MAN_W-1:0];
    assign e_fin       = e_base + EW'(man_sum[MAN_W]);
    assign unused_norm = norm[NW-1];
`else
    assign man_fin     = man_raw;
    assign e_fin       = e_base;
    assign unused_norm = ^{norm[NW-1], norm[NW-2-MAN_W:0]};
`endif

    // Exponent range check: flush to signed zero, or saturate to signed infinity.
    always_comb begin
        pack_float = {sign_reg, e_fin[EXP_W-1:0], man_fin};
        pack_oflow = 1'b0;
        pack_uflow = 1'b0;
        if (e_fin <= 0) begin
            pack_float = {sign_reg, {(EXP_W + MAN_W){1'b0}}};
            pack_uflow = 1'b1;
        end else if (e_fin >= E_MAX) begin
            pack_float = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_oflow = 1'b1;
        end
    end

    // Control FSM: capture, scan for the leading one, pack, then hold until the consumer accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            data_reg      <= '0;
            idx_reg       <= '0;
            sign_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_float_reg <= '0;
            out_lead_reg  <= '0;
            out_zero_reg  <= 1'b0;
            out_oflow_reg <= 1'b0;
            out_uflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        sign_reg <= in_sign;
                        idx_reg  <= LW'(IN_WIDTH - 1);
                        if (in_data == '0) begin
                            out_float_reg <= {in_sign, {(EXP_W + MAN_W){1'b0}}};
                            out_lead_reg  <= '0;
                            out_zero_reg  <= 1'b1;
                            out_oflow_reg <= 1'b0;
                            out_uflow_reg <= 1'b0;
                            state_reg     <= S_DONE;
                        end else begin
                            state_reg <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (data_reg[IN_WIDTH-1]) begin
                        state_reg <= S_PACK;
                    end else begin
                        data_reg <= {data_reg[IN_WIDTH-2:0], 1'b0};
                        idx_reg  <= idx_reg - 1'b1;
                    end
                end
                S_PACK: begin
                    out_float_reg <= pack_float;
                    out_lead_reg  <= idx_reg;
                    out_zero_reg  <= 1'b0;
                    out_oflow_reg <= pack_oflow;
                    out_uflow_reg <= pack_uflow;
                    state_reg     <= S_DONE;
                end
                default: begin
                    // DONE: the result is presented one cycle after it is entered, then held.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = out_valid_reg;
    assign out_float = out_float_reg;
    assign out_lead  = out_lead_reg;
    assign out_zero  = out_zero_reg;
    assign out_oflow = out_oflow_reg;
    assign out_uflow = out_uflow_reg;
endmodule
